// File: rtl/pixel_packer_pkg.sv
// Shared types and width helpers for the pixel stream packer.
// The optional luma accumulator is enabled by PIXEL_PACKER_LUMA_SUM_EN in the top.
package pixel_packer_pkg;

  typedef enum logic [1:0] {
    MODE_RGB    = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_NEG    = 2'd2,
    MODE_THRESH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  function automatic int calc_gh_w(input int ch_w);
    return ch_w / 2;
  endfunction

  function automatic int calc_word_w(input int ch_w);
    return 1 + (ch_w / 2) + ch_w;
  endfunction

endpackage

// File: rtl/pixel_mode_xform.sv
// Combinational per-mode pixel transform followed by truncation to CH_W bits.
module pixel_mode_xform
  import pixel_packer_pkg::*;
#(
  parameter int IN_W = 12,
  parameter int CH_W = 10
) (
  input  logic [IN_W-1:0] red,
  input  logic [IN_W-1:0] green,
  input  logic [IN_W-1:0] blue,
  input  logic [IN_W-1:0] gray,
  input  logic [IN_W-1:0] thresh,
  input  mode_e           mode,
  output logic [CH_W-1:0] red_ch,
  output logic [CH_W-1:0] green_ch,
  output logic [CH_W-1:0] blue_ch
);

  logic [IN_W-1:0] r_full;
  logic [IN_W-1:0] g_full;
  logic [IN_W-1:0] b_full;
  logic [IN_W-1:0] bin;

  always_comb begin
    bin    = (gray >= thresh) ? '1 : '0;
    r_full = red;
    g_full = green;
    b_full = blue;
    case (mode)
      MODE_GRAY: begin
        r_full = gray;
        g_full = gray;
        b_full = gray;
      end
      MODE_NEG: begin
        r_full = ~red;
        g_full = ~green;
        b_full = ~blue;
      end
      MODE_THRESH: begin
        r_full = bin;
        g_full = bin;
        b_full = bin;
      end
      default: ;
    endcase
    // Keep the most significant CH_W bits.
    red_ch   = r_full[IN_W-1 -: CH_W];
    green_ch = g_full[IN_W-1 -: CH_W];
    blue_ch  = b_full[IN_W-1 -: CH_W];
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Frame-locked pixel transform and two-word SDRAM packer with per-frame pixel count.
// Define PIXEL_PACKER_LUMA_SUM_EN to add the saturating per-frame gray sum output oLUMA_SUM.
module pixel_stream_packer
  import pixel_packer_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int CH_W  = 10,
  parameter int CNT_W = 24,
  localparam int GH_W   = calc_gh_w(CH_W),
  localparam int WORD_W = calc_word_w(CH_W)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFVAL,
  input  logic              iDVAL,
  input  logic [IN_W-1:0]   iRED,
  input  logic [IN_W-1:0]   iGREEN,
  input  logic [IN_W-1:0]   iBLUE,
  input  logic [IN_W-1:0]   iGRAY,
  input  logic [1:0]        iMODE,
  input  logic [IN_W-1:0]   iTHRESH,
  output logic [WORD_W-1:0] oWR1_DATA,
  output logic [WORD_W-1:0] oWR2_DATA,
  output logic              oDVAL,
  output logic              oFRAME_DONE,
  output logic [CNT_W-1:0]  oPIX_CNT,
  output logic [1:0]        oMODE,
  output logic [1:0]        oSTATE
`ifdef PIXEL_PACKER_LUMA_SUM_EN
  ,
  output logic [IN_W+CNT_W-1:0] oLUMA_SUM
`endif
);

  // Valid-only stream: a pixel is presented when iDVAL is high and is consumed
  // that cycle (no backpressure); oDVAL strobes exactly once per accepted pixel.
  state_e          state;
  mode_e           mode_q;
  logic [IN_W-1:0] thr_q;
  logic [CNT_W-1:0] cnt_q;
  logic            done_d1;
  logic            s1_valid;
  logic [CH_W-1:0] s1_r, s1_g, s1_b;

  logic            rise, fall, accept;
  mode_e           mode_eff;
  logic [IN_W-1:0] thr_eff;
  logic [CH_W-1:0] x_r, x_g, x_b;

  // ARMED is only reached after iFVAL was seen low, so iFVAL high there is a rising edge.
  assign rise     = (state == ST_ARMED) && iFVAL;
  assign fall     = (state == ST_ACTIVE) && !iFVAL;
  assign accept   = iFVAL && iDVAL && (state != ST_IDLE);
  assign mode_eff = rise ? mode_e'(iMODE) : mode_q;
  assign thr_eff  = rise ? iTHRESH : thr_q;
  assign oMODE    = mode_q;
  assign oSTATE   = state;

  pixel_mode_xform #(.IN_W(IN_W), .CH_W(CH_W)) u_xform (
    .red      (iRED),
    .green    (iGREEN),
    .blue     (iBLUE),
    .gray     (iGRAY),
    .thresh   (thr_eff),
    .mode     (mode_eff),
    .red_ch   (x_r),
    .green_ch (x_g),
    .blue_ch  (x_b)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_RGB;
      thr_q       <= '0;
      cnt_q       <= '0;
      done_d1     <= 1'b0;
      s1_valid    <= 1'b0;
      s1_r        <= '0;
      s1_g        <= '0;
      s1_b        <= '0;
      oDVAL       <= 1'b0;
      oWR1_DATA   <= '0;
      oWR2_DATA   <= '0;
      oFRAME_DONE <= 1'b0;
      oPIX_CNT    <= '0;
    end else begin
      case (state)
        ST_IDLE:   if (!iFVAL) state <= ST_ARMED;
        ST_ARMED: begin
          if (iFVAL) begin
            state  <= ST_ACTIVE;
            mode_q <= mode_e'(iMODE);
            thr_q  <= iTHRESH;
          end
        end
        ST_ACTIVE: if (!iFVAL) state <= ST_ARMED;
        default:   state <= ST_IDLE;
      endcase

      if (rise) cnt_q <= {{(CNT_W-1){1'b0}}, accept};
      else if (accept && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;

      // cnt_q cannot change on the fall cycle, so it is still final one cycle later.
      done_d1     <= fall;
      oFRAME_DONE <= done_d1;
      if (done_d1) oPIX_CNT <= cnt_q;

      s1_valid <= accept;
      if (accept) begin
        s1_r <= x_r;
        s1_g <= x_g;
        s1_b <= x_b;
      end

      oDVAL <= s1_valid;
      if (s1_valid) begin
        oWR1_DATA <= {1'b0, s1_g[CH_W-1:GH_W], s1_b};
        oWR2_DATA <= {1'b0, s1_g[GH_W-1:0], s1_r};
      end
    end
  end

`ifdef PIXEL_PACKER_LUMA_SUM_EN
  logic [IN_W+CNT_W-1:0] acc_q;
  logic [IN_W+CNT_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + (IN_W+CNT_W+1)'(iGRAY);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      acc_q     <= '0;
      oLUMA_SUM <= '0;
    end else begin
      if (rise) acc_q <= accept ? (IN_W+CNT_W)'(iGRAY) : '0;
      else if (accept) acc_q <= acc_sum[IN_W+CNT_W] ? '1 : acc_sum[IN_W+CNT_W-1:0];
      if (done_d1) oLUMA_SUM <= acc_q;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Self-checking bench for pixel_stream_packer: vector table, directed frame sequences
// and randomized frames scored against a frame-level reference model.
module tb_pixel_stream_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fval = 1'b0, dval = 1'b0;
  logic [11:0] red = '0, green = '0, blue = '0, gray = '0, thresh = '0;
  logic [1:0]  mode = '0;

  logic [15:0] wr1, wr2, s_wr1, s_wr2;
  logic        odval, done, s_dval, s_done;
  logic [23:0] pix_cnt;
  logic [3:0]  s_cnt;
  logic [1:0]  omode, ostate, s_mode, s_state;
`ifdef PIXEL_PACKER_LUMA_SUM_EN
  logic [35:0] luma;
  logic [15:0] s_luma;
`endif

  pixel_stream_packer #(.IN_W(12), .CH_W(10), .CNT_W(24)) dut (
    .iCLK(clk), .iRST(rst), .iFVAL(fval), .iDVAL(dval),
    .iRED(red), .iGREEN(green), .iBLUE(blue), .iGRAY(gray),
    .iMODE(mode), .iTHRESH(thresh),
    .oWR1_DATA(wr1), .oWR2_DATA(wr2), .oDVAL(odval), .oFRAME_DONE(done),
    .oPIX_CNT(pix_cnt), .oMODE(omode), .oSTATE(ostate)
`ifdef PIXEL_PACKER_LUMA_SUM_EN
    , .oLUMA_SUM(luma)
`endif
  );

  pixel_stream_packer #(.IN_W(12), .CH_W(10), .CNT_W(4)) dut_small (
    .iCLK(clk), .iRST(rst), .iFVAL(fval), .iDVAL(dval),
    .iRED(red), .iGREEN(green), .iBLUE(blue), .iGRAY(gray),
    .iMODE(mode), .iTHRESH(thresh),
    .oWR1_DATA(s_wr1), .oWR2_DATA(s_wr2), .oDVAL(s_dval), .oFRAME_DONE(s_done),
    .oPIX_CNT(s_cnt), .oMODE(s_mode), .oSTATE(s_state)
`ifdef PIXEL_PACKER_LUMA_SUM_EN
    , .oLUMA_SUM(s_luma)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_n = 0;
  int dval_seen = 0;

  // reference model state
  bit     synced = 0, in_frame = 0;
  int     m_mode = 0, m_thr = 0;
  longint m_cnt = 0, m_luma = 0;
  logic [31:0] exp_q[$];
  int          exp_due[$];
  int          done_due[$];
  longint      done_cnt[$];
  longint      done_luma[$];

  logic [15:0] cap_wr1, cap_wr2;
  longint      cap_cnt, cap_small;

  typedef struct {
    int r, g, b, gy, md, th;
    logic [15:0] e1, e2;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_n);
    end
  endtask

  // Expected {wr1, wr2} from the mode rules using plain integer arithmetic.
  function automatic logic [31:0] model_words(input int md, input int th, input int r,
                                              input int g, input int b, input int gy);
    int rr, gg, bb, w1, w2;
    case (md)
      1: begin rr = gy; gg = gy; bb = gy; end
      2: begin rr = 4095 - r; gg = 4095 - g; bb = 4095 - b; end
      3: begin rr = (gy >= th) ? 4095 : 0; gg = rr; bb = rr; end
      default: begin rr = r; gg = g; bb = b; end
    endcase
    rr = rr / 4; gg = gg / 4; bb = bb / 4;
    w1 = (gg / 32) * 1024 + bb;
    w2 = (gg % 32) * 1024 + rr;
    return {16'(w1), 16'(w2)};
  endfunction

  // One clock: check outputs at the negedge, then drive the next inputs and update the model.
  task automatic tick(input bit r_rst, input bit f, input bit d, input int rr, input int gg,
                      input int bb, input int gy, input int md, input int th);
    @(negedge clk);
    if (odval) begin
      cap_wr1 = wr1;
      cap_wr2 = wr2;
      dval_seen++;
    end
    if (exp_due.size() > 0 && exp_due[0] == tick_n) begin
      chk("dval", odval, 1);
      chk("small_dval", s_dval, 1);
      chk("words", {wr1, wr2}, exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_due.pop_front());
    end else if (odval || s_dval) begin
      chk("spurious_dval", {odval, s_dval}, 0);
    end
    if (done_due.size() > 0 && done_due[0] == tick_n) begin
      chk("frame_done", {done, s_done}, 2'b11);
      chk("pix_cnt", pix_cnt, done_cnt[0]);
      chk("small_pix_cnt", s_cnt, (done_cnt[0] > 15) ? 15 : done_cnt[0]);
`ifdef PIXEL_PACKER_LUMA_SUM_EN
      chk("luma_sum", luma, done_luma[0]);
      chk("small_luma_sum", s_luma, (done_luma[0] > 65535) ? 65535 : done_luma[0]);
`endif
      cap_cnt   = pix_cnt;
      cap_small = s_cnt;
      void'(done_due.pop_front());
      void'(done_cnt.pop_front());
      void'(done_luma.pop_front());
    end else if (done || s_done) begin
      chk("spurious_done", {done, s_done}, 0);
    end
    chk("mode", omode, m_mode);

    rst = r_rst; fval = f; dval = d;
    red = 12'(rr); green = 12'(gg); blue = 12'(bb); gray = 12'(gy);
    mode = 2'(md); thresh = 12'(th);

    if (r_rst) begin
      synced = 0; in_frame = 0; m_mode = 0;
      exp_q.delete(); exp_due.delete();
      done_due.delete(); done_cnt.delete(); done_luma.delete();
    end else begin
      if (!synced) begin
        if (!f) synced = 1;
      end else if (!in_frame && f) begin
        in_frame = 1; m_mode = md; m_thr = th; m_cnt = 0; m_luma = 0;
      end else if (in_frame && !f) begin
        in_frame = 0;
        done_due.push_back(tick_n + 2);
        done_cnt.push_back(m_cnt);
        done_luma.push_back(m_luma);
      end
      if (in_frame && f && d) begin
        exp_q.push_back(model_words(m_mode, m_thr, rr, gg, bb, gy));
        exp_due.push_back(tick_n + 2);
        if (m_cnt < 64'd16777215) m_cnt++;
        m_luma = m_luma + gy;
        if (m_luma > 64'h0000_000F_FFFF_FFFF) m_luma = 64'h0000_000F_FFFF_FFFF;
      end
    end
    tick_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 3), 0);
  endtask

  // Frame: rise cycle, n interior cycles, fall cycle. Negative gy/rr mean random values.
  task automatic run_frame(input int md, input int th, input int n, input bit gaps,
                           input bit edge_d, input int gy, input int rr);
    int g_v, r_v;
    g_v = (gy < 0) ? $urandom_range(0, 4095) : gy;
    r_v = (rr < 0) ? $urandom_range(0, 4095) : rr;
    tick(0, 1, edge_d, r_v, $urandom_range(0, 4095), $urandom_range(0, 4095), g_v, md, th);
    for (int i = 0; i < n; i++) begin
      g_v = (gy < 0) ? $urandom_range(0, 4095) : gy;
      r_v = (rr < 0) ? $urandom_range(0, 4095) : rr;
      tick(0, 1, gaps ? ($urandom_range(0, 3) != 0) : 1'b1, r_v, $urandom_range(0, 4095),
           $urandom_range(0, 4095), g_v, $urandom_range(0, 3), $urandom_range(0, 4095));
    end
    tick(0, 0, edge_d, 0, 0, 0, 0, md, th);
    idle(4);
  endtask

  initial begin
    vecs[0] = '{r: 'hABC, g: 'h5A5, b: 'h123, gy: 0,     md: 0, th: 0,     e1: 16'h2C48, e2: 16'h26AF};
    vecs[1] = '{r: 'h111, g: 'h222, b: 'h333, gy: 'h800, md: 1, th: 0,     e1: 16'h4200, e2: 16'h0200};
    vecs[2] = '{r: 0,     g: 0,     b: 0,     gy: 0,     md: 2, th: 0,     e1: 16'h7FFF, e2: 16'h7FFF};
    vecs[3] = '{r: 'h123, g: 'h456, b: 'h789, gy: 'h800, md: 3, th: 'h800, e1: 16'h7FFF, e2: 16'h7FFF};
    vecs[4] = '{r: 'hFFF, g: 'hFFF, b: 'hFFF, gy: 'h7FF, md: 3, th: 'h800, e1: 16'h0000, e2: 16'h0000};
    vecs[5] = '{r: 'hFFF, g: 0,     b: 'h555, gy: 0,     md: 2, th: 0,     e1: 16'h7EAA, e2: 16'h7C00};

    // reset and reset values
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("rst_wr1", wr1, 0);
    chk("rst_wr2", wr2, 0);
    chk("rst_dval", odval, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    chk("rst_mode", omode, 0);

    // vector table: each vector is a one-pixel frame accepted on the rising cycle
    foreach (vecs[k]) begin
      cap_wr1 = 16'hFFFF; cap_wr2 = 16'hFFFF; cap_cnt = -1;
      tick(0, 1, 1, vecs[k].r, vecs[k].g, vecs[k].b, vecs[k].gy, vecs[k].md, vecs[k].th);
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      chk($sformatf("vec%0d_wr1", k), cap_wr1, vecs[k].e1);
      chk($sformatf("vec%0d_wr2", k), cap_wr2, vecs[k].e2);
      chk($sformatf("vec%0d_cnt", k), cap_cnt, 1);
    end

    // frame-locked mode: gray frame with mid-frame mode changes
    run_frame(1, 0, 8, 0, 0, 'h800, -1);
    chk("locked_gray_red", cap_wr2[9:0], 10'h200);
    chk("locked_gray_cnt", cap_cnt, 8);
    run_frame(3, 'h800, 8, 0, 0, 'h800, -1);
    chk("thresh_eq_ones", cap_wr2[9:0], 10'h3FF);
    run_frame(3, 'h801, 8, 0, 0, 'h800, -1);
    chk("thresh_above_zero", cap_wr2[9:0], 10'h000);

    // edge coincidence: rising-cycle pixel counted, falling-cycle pixel dropped
    run_frame(0, 0, 10, 0, 1, -1, -1);
    chk("edge_cnt", cap_cnt, 11);

    // negative mode and counter saturation on the narrow instance
    run_frame(2, 0, 20, 0, 0, -1, 0);
    chk("neg_red_field", cap_wr2[9:0], 10'h3FF);
    chk("sat_small_cnt", cap_small, 15);
    chk("sat_wide_cnt", cap_cnt, 20);

    // reset in the middle of a frame: the rest of that frame is discarded
    tick(0, 1, 1, 1, 2, 3, 4, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, $urandom_range(0, 4095), 0, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0, 0, 0, 0);
    dval_seen = 0;
    tick(1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++)
      tick(0, 1, 1, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
           $urandom_range(0, 4095), 0, 0);
    idle(3);
    chk("no_dval_after_reset", dval_seen, 0);
    chk("no_done_after_reset", cap_cnt, 20);
    run_frame(0, 0, 12, 0, 0, -1, -1);
    chk("post_reset_frame_cnt", cap_cnt, 12);

    // long frame and randomized frames
    run_frame($urandom_range(0, 3), $urandom_range(0, 4095), 3000, 1, 1, -1, -1);
    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(0, 3), $urandom_range(0, 4095), $urandom_range(1, 60),
                1, $urandom_range(0, 1), -1, -1);

    idle(4);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_due.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
